// File: rtl/hwpe_eai_frontend.sv
// Purpose: HWPE-side EAI front end. Queues custom instructions in order, dispatches them to the core, returns one response each.
// Latency: accept->core_cmd_valid 2 cycles; core_done->eai_rsp_valid 1 cycle; illegal op accept->response 2 cycles.
// Backpressure: eai_req_ready drops when the command FIFO is full (reset instr always accepted); core/rsp ports are valid/ready.
//
// Ports: clk/rst (sync, active-high); eai_req_* request channel in; eai_rsp_* response channel out;
//        core_cmd_* command to HWPE core; core_done/core_result/core_err completion from core;
//        core_soft_rst one-cycle soft-reset pulse; busy = work outstanding.
module hwpe_eai_frontend #(
    parameter int unsigned DEPTH        = 4,
    parameter logic [6:0]  RESET_FUNCT7 = 7'h01,
    parameter logic [6:0]  MAX_FUNCT7   = 7'h0F
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        eai_req_valid,
    output logic        eai_req_ready,
    input  logic [31:0] eai_req_instr,
    input  logic [31:0] eai_req_rs1,
    input  logic [31:0] eai_req_rs2,
    input  logic [1:0]  eai_req_itag,
    output logic        eai_rsp_valid,
    input  logic        eai_rsp_ready,
    output logic [31:0] eai_rsp_wdat,
    output logic [1:0]  eai_rsp_itag,
    output logic        eai_rsp_err,
    output logic        core_cmd_valid,
    input  logic        core_cmd_ready,
    output logic [6:0]  core_cmd_op,
    output logic [31:0] core_cmd_rs1,
    output logic [31:0] core_cmd_rs2,
    input  logic        core_done,
    input  logic [31:0] core_result,
    input  logic        core_err,
    output logic        core_soft_rst,
    output logic        busy
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned PW = AW + 1;
    localparam logic [PW-1:0] PTR_ONE = PW'(1);

    typedef struct packed {
        logic [6:0]  op;
        logic [31:0] rs1;
        logic [31:0] rs2;
        logic [1:0]  itag;
        logic        ill;
    } cmd_t;

    typedef enum logic [2:0] {
        S_IDLE,
        S_ISSUE,
        S_WAIT,
        S_RESP,
        S_RRESP
    } state_t;

    cmd_t          mem [DEPTH];
    cmd_t          head;
    cmd_t          push_dat;
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    logic          full;
    logic          empty;

    logic [6:0]    req_f7;
    logic          req_is_rst;
    logic          push;
    logic          rst_acc;
    logic          pop;

    state_t        state;
    state_t        state_nxt;
    logic          rst_pend;
    logic [1:0]    rst_itag;
    logic          soft_rst_q;
    logic [31:0]   rsp_wdat_q;
    logic          rsp_err_q;
    logic          cap_en;
    logic [31:0]   cap_wdat;
    logic          cap_err;

    // Only funct7 selects the operation; the rest of the word is not decoded here.
    logic          unused_instr_bits;
    assign unused_instr_bits = ^eai_req_instr[24:0];

    assign req_f7     = eai_req_instr[31:25];
    assign req_is_rst = (req_f7 == RESET_FUNCT7);

    // Extra pointer MSB distinguishes full from empty when the indices match.
    assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign empty = (wr_ptr == rd_ptr);
    assign head  = mem[rd_ptr[AW-1:0]];

    // The soft-reset instruction bypasses the queue, so it is never blocked by a full FIFO.
    assign eai_req_ready = !rst && (!full || req_is_rst);
    assign push          = eai_req_valid && eai_req_ready && !req_is_rst;
    assign rst_acc       = eai_req_valid && eai_req_ready && req_is_rst;

    assign push_dat = '{op: req_f7, rs1: eai_req_rs1, rs2: eai_req_rs2,
                        itag: eai_req_itag, ill: (req_f7 > MAX_FUNCT7)};

    always_ff @(posedge clk) begin
        if (rst || rst_acc) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + PTR_ONE;
            if (pop)  rd_ptr <= rd_ptr + PTR_ONE;
        end
    end

    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr[AW-1:0]] <= push_dat;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= S_IDLE;
            rst_pend   <= 1'b0;
            rst_itag   <= '0;
            soft_rst_q <= 1'b0;
            rsp_wdat_q <= '0;
            rsp_err_q  <= 1'b0;
        end else begin
            state      <= state_nxt;
            soft_rst_q <= rst_acc;
            if (rst_acc) begin
                rst_pend <= 1'b1;
                rst_itag <= eai_req_itag;
            end else if (state == S_RRESP && eai_rsp_ready) begin
                rst_pend <= 1'b0;
            end
            if (cap_en) begin
                rsp_wdat_q <= cap_wdat;
                rsp_err_q  <= cap_err;
            end
        end
    end

    always_comb begin
        state_nxt      = state;
        pop            = 1'b0;
        cap_en         = 1'b0;
        cap_wdat       = '0;
        cap_err        = 1'b0;
        core_cmd_valid = 1'b0;
        core_cmd_op    = '0;
        core_cmd_rs1   = '0;
        core_cmd_rs2   = '0;
        eai_rsp_valid  = 1'b0;
        eai_rsp_wdat   = '0;
        eai_rsp_itag   = '0;
        eai_rsp_err    = 1'b0;
        case (state)
            S_IDLE: begin
                if (rst_pend) begin
                    state_nxt = S_RRESP;
                end else if (!empty) begin
                    if (head.ill) begin
                        // Illegal ops never reach the core; answer with an error directly.
                        state_nxt = S_RESP;
                        cap_en    = 1'b1;
                        cap_err   = 1'b1;
                    end else begin
                        state_nxt = S_ISSUE;
                    end
                end
            end
            S_ISSUE: begin
                core_cmd_valid = 1'b1;
                core_cmd_op    = head.op;
                core_cmd_rs1   = head.rs1;
                core_cmd_rs2   = head.rs2;
                if (core_cmd_ready) begin
                    if (core_done) begin
                        state_nxt = S_RESP;
                        cap_en    = 1'b1;
                        cap_wdat  = core_result;
                        cap_err   = core_err;
                    end else begin
                        state_nxt = S_WAIT;
                    end
                end
            end
            S_WAIT: begin
                if (core_done) begin
                    state_nxt = S_RESP;
                    cap_en    = 1'b1;
                    cap_wdat  = core_result;
                    cap_err   = core_err;
                end
            end
            S_RESP: begin
                eai_rsp_valid = 1'b1;
                eai_rsp_wdat  = rsp_wdat_q;
                eai_rsp_err   = rsp_err_q;
                eai_rsp_itag  = head.itag;
                if (eai_rsp_ready) begin
                    pop       = 1'b1;
                    state_nxt = S_IDLE;
                end
            end
            S_RRESP: begin
                eai_rsp_valid = 1'b1;
                eai_rsp_itag  = rst_itag;
                if (eai_rsp_ready) state_nxt = S_IDLE;
            end
            default: state_nxt = S_IDLE;
        endcase
        // A soft reset abandons whatever is in flight; its response is never sent.
        if (rst_acc) state_nxt = S_IDLE;
    end

    assign core_soft_rst = soft_rst_q;
    assign busy          = (state != S_IDLE) || !empty || rst_pend;

endmodule
